// File: rtl/dmem_if.sv
// Load/store bus between the MIPS core MEM stage (master) and a data-memory responder (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed request-to-ack latency for the MIPS load/store port.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               mem_we_c;
  logic               misalign_c;
  logic [ADDR_W-1:0]  idx_c;
  logic               unused_addr_c;
  logic [31:0]        mem [DEPTH];

  assign idx_c         = addr_q[ADDR_W+1:2];
  assign unused_addr_c = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign misalign_c = (addr_q[1:0] != 2'b00);
  assign bus.err    = err_q;
`else
  assign misalign_c = 1'b0;
  assign bus.err    = 1'b0;
`endif

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = 32'h0;
    ack_d    = 1'b0;
    busy_d   = (state_q != S_IDLE);
    mem_we_c = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
        // A trapped access touches neither the array nor rdata
        if (misalign_c) begin
`ifdef DMEM_MISALIGN_TRAP_EN
          err_d = 1'b1;
`endif
        end else if (we_q) begin
          mem_we_c = 1'b1;
        end else begin
          rdata_d = mem[idx_c];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Array is never reset; a store commits only on its RESP edge
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances, WAIT_STATES=2 and WAIT_STATES=0.
module tb_dmem_responder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_if b2();
  dmem_if b0();

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req2(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d;
    step();
    b2.req = 1'b0;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (b2.ack) begin
        lat = i; rd = b2.rdata; er = b2.err;
        break;
      end
    end
  endtask

  task automatic do_req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    b0.req = 1'b1; b0.we = w; b0.addr = a; b0.wdata = d;
    step();
    b0.req = 1'b0;
    lat = -1; rd = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (b0.ack) begin
        lat = i; rd = b0.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (b2.ack !== 1'b0)      begin errors++; $display("FAIL reset_ack got=%b exp=0", b2.ack); end
    checks++; if (b2.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", b2.busy); end
    checks++; if (b2.rdata !== 32'h0)   begin errors++; $display("FAIL reset_rdata got=%h exp=0", b2.rdata); end
    checks++; if (b2.err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b exp=0", b2.err); end
    checks++; if (b0.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy0 got=%b exp=0", b0.busy); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b1, 32'h10, 32'h1111_2222, rd, er, lat);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h10; b2.wdata = 32'hDEAD_BEEF;
    step();
    b2.req = 1'b0;
    step();
    checks++; if (b2.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", b2.busy); end
    rst = 1'b0;
    #1;
    checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", b2.busy); end
    checks++; if (b2.ack !== 1'b0)  begin errors++; $display("FAIL abort_ack got=%b exp=0", b2.ack); end
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++; if (b2.ack !== 1'b0)  begin errors++; $display("FAIL abort_no_ack got=%b exp=0", b2.ack); end
    do_req2(1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL abort_load got=%h exp=11112222", rd); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat;
    logic exp_busy, exp_ack;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h40; b2.wdata = 32'h1234_5678;
    step();
    b2.req = 1'b0;
    checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL lat_busy_c0 got=%b exp=0", b2.busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_busy = (k <= 3);
      exp_ack  = (k == 3);
      checks++; if (b2.busy !== exp_busy) begin errors++; $display("FAIL lat_busy_c%0d got=%b exp=%b", k, b2.busy, exp_busy); end
      checks++; if (b2.ack !== exp_ack)   begin errors++; $display("FAIL lat_ack_c%0d got=%b exp=%b", k, b2.ack, exp_ack); end
      if (k == 3) begin
        checks++; if (b2.rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got=%h exp=0", b2.rdata); end
      end
    end
    do_req2(1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (lat != 3)              begin errors++; $display("FAIL load_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h1234_5678)  begin errors++; $display("FAIL load_data got=%h exp=12345678", rd); end
    checks++; if (er !== 1'b0)           begin errors++; $display("FAIL load_err got=%b exp=0", er); end
    step();
    checks++; if (b2.rdata !== 32'h0)    begin errors++; $display("FAIL rdata_after_ack got=%h exp=0", b2.rdata); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; int lat;
    do_req0(1'b1, 32'h80, 32'hCAFE_0001, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL ws0_store_lat got=%0d exp=1", lat); end
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h80;
    step();
    b0.req = 1'b0;
    checks++; if (b0.busy !== 1'b0)          begin errors++; $display("FAIL ws0_busy_c0 got=%b exp=0", b0.busy); end
    step();
    checks++; if (b0.busy !== 1'b1)          begin errors++; $display("FAIL ws0_busy_c1 got=%b exp=1", b0.busy); end
    checks++; if (b0.ack !== 1'b1)           begin errors++; $display("FAIL ws0_ack_c1 got=%b exp=1", b0.ack); end
    checks++; if (b0.rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL ws0_rdata got=%h exp=cafe0001", b0.rdata); end
    step();
    checks++; if (b0.busy !== 1'b0)          begin errors++; $display("FAIL ws0_busy_c2 got=%b exp=0", b0.busy); end
    checks++; if (b0.ack !== 1'b0)           begin errors++; $display("FAIL ws0_ack_c2 got=%b exp=0", b0.ack); end
  endtask

  task automatic test_req_held();
    int n2, bad2, n0, bad0;
    n2 = 0; bad2 = 0; n0 = 0; bad0 = 0;
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h40;
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h80;
    for (int k = 0; k < 16; k++) begin
      step();
      if (b2.ack) begin n2++; if ((k % 4) != 3) bad2++; end
      if (b0.ack) begin n0++; if ((k % 2) != 1) bad0++; end
    end
    b2.req = 1'b0; b0.req = 1'b0;
    checks++; if (n2 != 4)   begin errors++; $display("FAIL held_ack_count2 got=%0d exp=4", n2); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL held_ack_spacing2 got=%0d exp=0", bad2); end
    checks++; if (n0 != 8)   begin errors++; $display("FAIL held_ack_count0 got=%0d exp=8", n0); end
    checks++; if (bad0 != 0) begin errors++; $display("FAIL held_ack_spacing0 got=%0d exp=0", bad0); end
    step(); step();
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic er; int lat;
    do_req2(1'b1, 32'h0000_1000, 32'hAAAA_0001, rd, er, lat);
    do_req2(1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hAAAA_0001) begin errors++; $display("FAIL alias_load got=%h exp=aaaa0001", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    logic        exp_err;
    logic [31:0] exp_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_err  = 1'b1;
    exp_data = 32'h1234_5678;
`else
    exp_err  = 1'b0;
    exp_data = 32'h5555_6666;
`endif
    do_req2(1'b1, 32'h42, 32'h5555_6666, rd, er, lat);
    checks++; if (lat != 3)       begin errors++; $display("FAIL mis_lat got=%0d exp=3", lat); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL mis_err got=%b exp=%b", er, exp_err); end
    checks++; if (rd !== 32'h0)   begin errors++; $display("FAIL mis_rdata got=%h exp=0", rd); end
    do_req2(1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_data) begin errors++; $display("FAIL mis_load got=%h exp=%h", rd, exp_data); end
    checks++; if (er !== 1'b0)     begin errors++; $display("FAIL mis_load_err got=%b exp=0", er); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = 32'h0; b2.wdata = 32'h0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = 32'h0; b0.wdata = 32'h0;
    step(); step();
    test_reset();
    rst = 1'b1;
    step();
    test_reset_abort();
    test_latency();
    test_zero_wait();
    test_req_held();
    test_alias();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
